// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor elevator controller serving latched calls in SCAN order.
// Models timed travel between floors and a timed door-open phase.
// Ports:
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous active-low reset
//   req        in   NUM_FLOORS  call buttons, bit i = call to floor i
//   cur_floor  out  FLR_W       current / last-passed floor
//   moving     out  1           car travelling (up or down)
//   dir_up     out  1           current / last direction, 1 = up
//   door_open  out  1           door phase active
//   pending    out  NUM_FLOORS  latched, unserved calls
module elevator_ctrl_n #(
   parameter int unsigned NUM_FLOORS = 4,
   parameter int unsigned FLR_W      = 2,
   parameter int unsigned TRAVEL_CYC = 4,
   parameter int unsigned DOOR_CYC   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] req,
   output logic [FLR_W-1:0]      cur_floor,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int unsigned TRAV_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
   localparam int unsigned DOOR_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
   localparam logic [FLR_W-1:0] TOP = FLR_W'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MOVE_UP = 2'd1,
      MOVE_DN = 2'd2,
      DOOR    = 2'd3
   } state_t;

   state_t              state;
   logic [TRAV_W-1:0]   trav_cnt;
   logic [DOOR_W-1:0]   door_cnt;

   // Floor masks: exactly f, strictly above f, strictly below f.
   function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < int'(NUM_FLOORS); i++) m[i] = (i == int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] gt_mask(input logic [FLR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < int'(NUM_FLOORS); i++) m[i] = (i > int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] lt_mask(input logic [FLR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < int'(NUM_FLOORS); i++) m[i] = (i < int'(f));
      return m;
   endfunction

   logic [FLR_W-1:0]      nf_up, nf_dn;
   logic                  here, above, below, req_here;
   logic                  here_up, ahead_up, here_dn, ahead_dn;
   logic                  trav_term, door_term, arrive_up, arrive_dn;
   logic [NUM_FLOORS-1:0] clr;

   // Neighbour floors saturate at the ends so indices stay in range.
   assign nf_up     = (cur_floor == TOP) ? cur_floor : cur_floor + FLR_W'(1);
   assign nf_dn     = (cur_floor == '0)  ? cur_floor : cur_floor - FLR_W'(1);

   assign here      = |(pending & onehot(cur_floor));
   assign above     = |(pending & gt_mask(cur_floor));
   assign below     = |(pending & lt_mask(cur_floor));
   assign req_here  = |(req & onehot(cur_floor));
   assign here_up   = |(pending & onehot(nf_up));
   assign ahead_up  = |(pending & gt_mask(nf_up));
   assign here_dn   = |(pending & onehot(nf_dn));
   assign ahead_dn  = |(pending & lt_mask(nf_dn));

   assign trav_term = (trav_cnt == TRAV_W'(TRAVEL_CYC - 1));
   assign door_term = (door_cnt == DOOR_W'(DOOR_CYC - 1));
   assign arrive_up = trav_term && (cur_floor != TOP);
   assign arrive_dn = trav_term && (cur_floor != '0);

   // Call-clear mask: the floor being served; in DOOR it also blocks re-latching.
   always_comb begin
      clr = '0;
      case (state)
         IDLE:    if (here)                  clr = onehot(cur_floor);
         MOVE_UP: if (arrive_up && here_up)  clr = onehot(nf_up);
         MOVE_DN: if (arrive_dn && here_dn)  clr = onehot(nf_dn);
         DOOR:                               clr = onehot(cur_floor);
         default: clr = '0;
      endcase
   end

   // Controller state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cur_floor <= '0;
         dir_up    <= 1'b1;
         pending   <= '0;
         trav_cnt  <= '0;
         door_cnt  <= '0;
         moving    <= 1'b0;
         door_open <= 1'b0;
      end else begin
         pending <= (pending | req) & ~clr;
         case (state)
            IDLE: begin
               trav_cnt <= '0;
               door_cnt <= '0;
               if (here) begin
                  state     <= DOOR;
                  door_open <= 1'b1;
               end else if (above && (dir_up || !below)) begin
                  state  <= MOVE_UP;
                  moving <= 1'b1;
                  dir_up <= 1'b1;
               end else if (below) begin
                  state  <= MOVE_DN;
                  moving <= 1'b1;
                  dir_up <= 1'b0;
               end
            end

            MOVE_UP: begin
               if (cur_floor == TOP) begin
                  state    <= IDLE;
                  moving   <= 1'b0;
                  trav_cnt <= '0;
               end else if (trav_term) begin
                  trav_cnt  <= '0;
                  cur_floor <= nf_up;
                  if (here_up) begin
                     state     <= DOOR;
                     moving    <= 1'b0;
                     door_open <= 1'b1;
                     door_cnt  <= '0;
                  end else if (!ahead_up) begin
                     state  <= IDLE;
                     moving <= 1'b0;
                  end
               end else begin
                  trav_cnt <= trav_cnt + TRAV_W'(1);
               end
            end

            MOVE_DN: begin
               if (cur_floor == '0) begin
                  state    <= IDLE;
                  moving   <= 1'b0;
                  trav_cnt <= '0;
               end else if (trav_term) begin
                  trav_cnt  <= '0;
                  cur_floor <= nf_dn;
                  if (here_dn) begin
                     state     <= DOOR;
                     moving    <= 1'b0;
                     door_open <= 1'b1;
                     door_cnt  <= '0;
                  end else if (!ahead_dn) begin
                     state  <= IDLE;
                     moving <= 1'b0;
                  end
               end else begin
                  trav_cnt <= trav_cnt + TRAV_W'(1);
               end
            end

            DOOR: begin
               // A call for this floor holds the door open by restarting the count.
               if (req_here) begin
                  door_cnt <= '0;
               end else if (door_term) begin
                  state     <= IDLE;
                  door_open <= 1'b0;
                  door_cnt  <= '0;
               end else begin
                  door_cnt <= door_cnt + DOOR_W'(1);
               end
            end

            default: begin
               state     <= IDLE;
               moving    <= 1'b0;
               door_open <= 1'b0;
               trav_cnt  <= '0;
               door_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed self-checking bench for elevator_ctrl_n
// (4-floor instance plus an 8-floor instance sharing clock and reset).
module tb_elevator_ctrl_n;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [1:0] cur_floor;
   logic       moving, dir_up, door_open;
   logic [3:0] pending;

   logic [7:0] req8;
   logic [2:0] cur_floor8;
   logic       moving8, dir_up8, door_open8;
   logic [7:0] pending8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   elevator_ctrl_n #(.NUM_FLOORS(4), .FLR_W(2), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
      .clk(clk), .rst(rst), .req(req), .cur_floor(cur_floor), .moving(moving),
      .dir_up(dir_up), .door_open(door_open), .pending(pending)
   );

   elevator_ctrl_n #(.NUM_FLOORS(8), .FLR_W(3), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut8 (
      .clk(clk), .rst(rst), .req(req8), .cur_floor(cur_floor8), .moving(moving8),
      .dir_up(dir_up8), .door_open(door_open8), .pending(pending8)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance until the door opens; count cycles spent moving on the way.
   task automatic travel(output int mv, output logic ok);
      mv = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (door_open) begin
            ok = 1'b1;
            break;
         end
         if (moving) mv++;
      end
   endtask

   // Count cycles the door stays open, starting with the door already open.
   task automatic door_len(output int n);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (!door_open) break;
         n++;
         tick(1);
      end
   endtask

   int   mv, dn, prev8;
   logic ok, wrapped;

   initial begin
      // Reset held two cycles with all calls asserted.
      rst  = 1'b0;
      req  = 4'b1111;
      req8 = 8'hff;
      tick(2);
      chk("rst_floor",   32'(cur_floor), 0);
      chk("rst_pending", 32'(pending),   0);
      chk("rst_moving",  32'(moving),    0);
      chk("rst_door",    32'(door_open), 0);
      chk("rst_dir",     32'(dir_up),    1);
      chk("rst8_pending", 32'(pending8), 0);
      rst  = 1'b1;
      req  = 4'b0000;
      req8 = 8'h00;
      tick(1);

      // Single call to floor 2: 8 cycles moving up, door 3 cycles.
      req = 4'b0100;
      tick(1);
      req = 4'b0000;
      chk("single_latch",  32'(pending), 32'h4);
      chk("single_idle",   32'(moving),  0);
      travel(mv, ok);
      chk("single_arrive", 32'(ok),        1);
      chk("single_moves",  32'(mv),        8);
      chk("single_floor",  32'(cur_floor), 2);
      chk("single_dir",    32'(dir_up),    1);
      chk("single_clr",    32'(pending),   0);
      door_len(dn);
      chk("single_door",   32'(dn),        3);
      chk("single_stop",   32'(moving),    0);

      // Door extend at floor 2: call for floor 2 on 2nd door cycle -> 5 cycles open.
      req = 4'b0100;
      tick(1);
      req = 4'b0000;
      chk("ext_latch", 32'(pending),   32'h4);
      chk("ext_c0",    32'(door_open), 0);
      tick(1);
      chk("ext_c1",    32'(door_open), 1);
      chk("ext_clr",   32'(pending),   0);
      tick(1);
      chk("ext_c2",    32'(door_open), 1);
      req = 4'b0100;
      tick(1);
      req = 4'b0000;
      chk("ext_c3",    32'(door_open), 1);
      chk("ext_nolat", 32'(pending),   0);
      tick(1);
      chk("ext_c4",    32'(door_open), 1);
      tick(1);
      chk("ext_c5",    32'(door_open), 1);
      tick(1);
      chk("ext_close", 32'(door_open), 0);
      chk("ext_still", 32'(moving),    0);

      // Call to floor 0 from floor 2: moves down 8 cycles.
      req = 4'b0001;
      tick(1);
      req = 4'b0000;
      travel(mv, ok);
      chk("down_arrive", 32'(ok),        1);
      chk("down_moves",  32'(mv),        8);
      chk("down_floor",  32'(cur_floor), 0);
      chk("down_dir",    32'(dir_up),    0);
      door_len(dn);
      chk("down_door",   32'(dn),        3);

      // Call at current floor while idle: door next+1 cycle, no motion.
      req = 4'b0001;
      tick(1);
      req = 4'b0000;
      chk("here_wait",  32'(door_open), 0);
      travel(mv, ok);
      chk("here_open",  32'(ok),        1);
      chk("here_moves", 32'(mv),        0);
      chk("here_clr",   32'(pending),   0);
      chk("here_floor", 32'(cur_floor), 0);
      door_len(dn);
      chk("here_door",  32'(dn),        3);

      // SCAN: heading up to 3, call to 0 at floor 1 waits until reversal.
      req = 4'b1000;
      tick(1);
      req = 4'b0000;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cur_floor == 2'd1) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      chk("scan_reach1", 32'(ok), 1);
      req = 4'b0001;
      tick(1);
      req = 4'b0000;
      chk("scan_latch",  32'(pending), 32'h9);
      chk("scan_up",     32'(dir_up),  1);
      travel(mv, ok);
      chk("scan_arr3",   32'(ok),        1);
      chk("scan_mv3",    32'(mv),        6);
      chk("scan_floor3", 32'(cur_floor), 3);
      chk("scan_dir3",   32'(dir_up),    1);
      chk("scan_pend3",  32'(pending),   32'h1);
      door_len(dn);
      chk("scan_door3",  32'(dn),        3);
      travel(mv, ok);
      chk("scan_arr0",   32'(ok),        1);
      chk("scan_mv0",    32'(mv),        12);
      chk("scan_floor0", 32'(cur_floor), 0);
      chk("scan_dir0",   32'(dir_up),    0);
      chk("scan_pend0",  32'(pending),   0);
      door_len(dn);
      chk("scan_door0",  32'(dn),        3);

      // Reset mid-travel between floors 1 and 2.
      req = 4'b1000;
      tick(1);
      req = 4'b0000;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cur_floor == 2'd1) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      chk("mid_reach1", 32'(ok), 1);
      tick(2);
      chk("mid_moving", 32'(moving), 1);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      chk("mid_floor",   32'(cur_floor), 0);
      chk("mid_pending", 32'(pending),   0);
      chk("mid_moving0", 32'(moving),    0);
      chk("mid_door",    32'(door_open), 0);
      chk("mid_dir",     32'(dir_up),    1);

      // 8-floor instance: call to floor 7 climbs monotonically, no wrap.
      req8 = 8'h80;
      tick(1);
      req8 = 8'h00;
      mv = 0;
      ok = 1'b0;
      wrapped = 1'b0;
      prev8 = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (int'(cur_floor8) < prev8) wrapped = 1'b1;
         prev8 = int'(cur_floor8);
         if (door_open8) begin
            ok = 1'b1;
            break;
         end
         if (moving8) mv++;
      end
      chk("f8_arrive",  32'(ok),         1);
      chk("f8_moves",   32'(mv),         28);
      chk("f8_floor",   32'(cur_floor8), 7);
      chk("f8_nowrap",  32'(wrapped),    0);
      chk("f8_pending", 32'(pending8),   0);
      tick(4);
      chk("f8_closed",  32'(door_open8), 0);
      chk("f8_stay",    32'(cur_floor8), 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
